control_unit: RTL
=================

CONTROL_UNIT -- requirements
Module: control_unit

Interface
REQ-001 Parameter RETIRE_CNT_WIDTH, default 32: width of the retired-instruction counter.
REQ-002 control_unit_clock_in  input  1  single clock; all state updates on its rising edge.
REQ-003 control_unit_reset_in  input  1  asynchronous, active-high reset.
REQ-004 control_unit_opcode_in  input  7  IR[6:0] from the datapath.
REQ-005 control_unit_branch_taken_in  input  1  branch comparison result, valid in EXECUTE.
REQ-006 control_unit_ins_ack_in  input  1  instruction memory data valid.
REQ-007 control_unit_data_ack_in  input  1  data memory access complete.
REQ-008 control_unit_ins_req_out  output  1  instruction fetch request.
REQ-009 control_unit_data_req_out  output  1  data memory request.
REQ-010 control_unit_data_we_out  output  1  data memory write enable (store).
REQ-011 control_unit_ir_set_out  output  1  IR load strobe.
REQ-012 control_unit_pc_set_out  output  1  PC load strobe.
REQ-013 control_unit_pc_mux_sel_out  output  2  0 = PC+4, 1 = PC+offset, 2 = register target, 3 unused.
REQ-014 control_unit_imm_mux_sel_out  output  1  1 when opcode is OP-IMM, LOAD, STORE, JALR, LUI or AUIPC; else 0.
REQ-015 control_unit_gpr_we_out  output  1  register file write enable.
REQ-016 control_unit_illegal_out  output  1  sticky illegal-opcode flag.
REQ-017 control_unit_retired_out  output  RETIRE_CNT_WIDTH  retired-instruction count.

Function
REQ-018 Multicycle FSM, states FETCH, DECODE, EXECUTE, MEMORY, WRITEBACK, TRAP; all outputs are decoded from current state, registered opcode and inputs only.
REQ-019 FETCH: ins_req_out=1; ins_ack_in=0 -> stay; ins_ack_in=1 -> ir_set_out=1 that cycle, next DECODE.
REQ-020 DECODE: opcode latched internally from opcode_in; legal set {0110111, 0010111, 1101111, 1100111, 1100011, 0000011, 0100011, 0010011, 0110011}; legal -> EXECUTE, otherwise -> TRAP.
REQ-021 EXECUTE transitions: LOAD/STORE -> MEMORY; BRANCH -> FETCH; all other legal opcodes -> WRITEBACK.
REQ-022 BRANCH in EXECUTE: pc_set_out=1, pc_mux_sel_out=1 if branch_taken_in else 0.
REQ-023 MEMORY: data_req_out=1, data_we_out=1 for STORE only; data_ack_in=0 -> stay; on ack LOAD -> WRITEBACK, STORE -> FETCH with pc_set_out=1, pc_mux_sel_out=0 that cycle.
REQ-024 WRITEBACK: gpr_we_out=1, pc_set_out=1 for one cycle, pc_mux_sel_out = 1 for JAL, 2 for JALR, else 0; next FETCH.
REQ-025 pc_set_out pulses exactly once per retired instruction, on its last cycle; retired_out increments by 1 in that same cycle and wraps modulo 2^RETIRE_CNT_WIDTH.
REQ-026 TRAP: illegal_out=1, all request/strobe/enable outputs 0, remains until reset.
REQ-027 Outside the states named above ins_req_out, data_req_out, data_we_out, ir_set_out, pc_set_out, gpr_we_out are 0; pc_mux_sel_out is 0 when pc_set_out=0.
REQ-028 Latency with zero-wait acks: OP/OP-IMM/LUI/AUIPC/JAL/JALR 4 cycles, BRANCH 3, STORE 4, LOAD 5.
REQ-029 A request (ins_req_out, data_req_out) is held high continuously until its ack; acks arriving in any other state are ignored.

Reset
REQ-030 Reset asserted: state FETCH, latched opcode 0, illegal_out 0, retired_out 0, all strobes/requests 0, immediately and independent of the clock.
REQ-031 Reset asserted mid-access aborts the access; requests drop asynchronously and no pc_set, gpr_we or counter increment occurs.
REQ-032 First cycle after reset release: FSM in FETCH, ins_req_out=1.

Verification
REQ-033 ADD (0110011), ins_ack on first FETCH cycle -> ir_set cycle 1, gpr_we+pc_set with sel 0 cycle 4, retired_out 0->1.
REQ-034 LOAD with data_ack delayed 3 cycles -> data_req high 4 cycles, data_we 0, gpr_we in WRITEBACK, total 8 cycles.
REQ-035 BRANCH taken=1 then taken=0 -> pc_set in EXECUTE with sel 1 then sel 0, gpr_we never asserted.
REQ-036 Opcode 1111111 -> TRAP after DECODE, illegal_out=1, no further ins_req; reset clears illegal_out to 0.
REQ-037 Reset asserted while data_req high for STORE -> data_req/data_we drop same cycle, retired_out unchanged at 0.
REQ-038 RETIRE_CNT_WIDTH=4, 16 ADDs -> retired_out wraps 15->0.

Source files
------------

// File: rtl/control_unit.sv
// Multicycle control FSM: sequences fetch/decode/execute/memory/writeback for a
// small RV32I subset, drives datapath strobes and counts retired instructions.
module control_unit #(
  parameter int RETIRE_CNT_WIDTH = 32
) (
  input  logic                        control_unit_clock_in,
  input  logic                        control_unit_reset_in,
  input  logic [6:0]                  control_unit_opcode_in,
  input  logic                        control_unit_branch_taken_in,
  input  logic                        control_unit_ins_ack_in,
  input  logic                        control_unit_data_ack_in,
  output logic                        control_unit_ins_req_out,
  output logic                        control_unit_data_req_out,
  output logic                        control_unit_data_we_out,
  output logic                        control_unit_ir_set_out,
  output logic                        control_unit_pc_set_out,
  output logic [1:0]                  control_unit_pc_mux_sel_out,
  output logic                        control_unit_imm_mux_sel_out,
  output logic                        control_unit_gpr_we_out,
  output logic                        control_unit_illegal_out,
  output logic [RETIRE_CNT_WIDTH-1:0] control_unit_retired_out
);

  typedef enum logic [2:0] {FETCH, DECODE, EXECUTE, MEMORY, WRITEBACK, TRAP} state_t;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_OP     = 7'b0110011;

  state_t                      state, state_nxt;
  logic [6:0]                  opcode_q;
  logic [RETIRE_CNT_WIDTH-1:0] retired_q;
  logic                        ins_req, data_req, data_we, ir_set, pc_set, gpr_we;
  logic [1:0]                  pc_sel;
  logic                        legal;

  always_comb begin
    case (control_unit_opcode_in)
      OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_BRANCH,
      OP_LOAD, OP_STORE, OP_IMM, OP_OP: legal = 1'b1;
      default:                          legal = 1'b0;
    endcase
  end

  always_ff @(posedge control_unit_clock_in or posedge control_unit_reset_in) begin
    if (control_unit_reset_in) begin
      state    <= FETCH;
      opcode_q <= 7'd0;
    end else begin
      state <= state_nxt;
      if (state == DECODE) opcode_q <= control_unit_opcode_in;
    end
  end

  always_comb begin
    state_nxt = state;
    ins_req   = 1'b0;
    data_req  = 1'b0;
    data_we   = 1'b0;
    ir_set    = 1'b0;
    pc_set    = 1'b0;
    pc_sel    = 2'd0;
    gpr_we    = 1'b0;
    case (state)
      FETCH: begin
        ins_req = 1'b1;
        if (control_unit_ins_ack_in) begin
          ir_set    = 1'b1;
          state_nxt = DECODE;
        end
      end
      DECODE: state_nxt = legal ? EXECUTE : TRAP;
      EXECUTE: begin
        if (opcode_q == OP_LOAD || opcode_q == OP_STORE) begin
          state_nxt = MEMORY;
        end else if (opcode_q == OP_BRANCH) begin
          pc_set    = 1'b1;
          pc_sel    = control_unit_branch_taken_in ? 2'd1 : 2'd0;
          state_nxt = FETCH;
        end else begin
          state_nxt = WRITEBACK;
        end
      end
      MEMORY: begin
        data_req = 1'b1;
        data_we  = (opcode_q == OP_STORE);
        if (control_unit_data_ack_in) begin
          if (opcode_q == OP_STORE) begin
            pc_set    = 1'b1;
            state_nxt = FETCH;
          end else begin
            state_nxt = WRITEBACK;
          end
        end
      end
      WRITEBACK: begin
        gpr_we    = 1'b1;
        pc_set    = 1'b1;
        pc_sel    = (opcode_q == OP_JAL) ? 2'd1 : (opcode_q == OP_JALR) ? 2'd2 : 2'd0;
        state_nxt = FETCH;
      end
      TRAP:    state_nxt = TRAP;
      default: state_nxt = FETCH;
    endcase
  end

  // Counter advances on the same cycle as the pc_set pulse that retires an instruction.
  always_ff @(posedge control_unit_clock_in or posedge control_unit_reset_in) begin
    if (control_unit_reset_in) retired_q <= '0;
    else if (pc_set)           retired_q <= retired_q + 1'b1;
  end

  // Reset must silence strobes immediately, even though FETCH would otherwise request.
  assign control_unit_ins_req_out    = ins_req  & ~control_unit_reset_in;
  assign control_unit_data_req_out   = data_req & ~control_unit_reset_in;
  assign control_unit_data_we_out    = data_we  & ~control_unit_reset_in;
  assign control_unit_ir_set_out     = ir_set   & ~control_unit_reset_in;
  assign control_unit_pc_set_out     = pc_set   & ~control_unit_reset_in;
  assign control_unit_gpr_we_out     = gpr_we   & ~control_unit_reset_in;
  assign control_unit_pc_mux_sel_out = control_unit_reset_in ? 2'd0 : pc_sel;
  assign control_unit_imm_mux_sel_out = (opcode_q == OP_IMM)  || (opcode_q == OP_LOAD) ||
                                        (opcode_q == OP_STORE) || (opcode_q == OP_JALR) ||
                                        (opcode_q == OP_LUI)   || (opcode_q == OP_AUIPC);
  assign control_unit_illegal_out    = (state == TRAP);
  assign control_unit_retired_out    = retired_q;

endmodule
